// File: rtl/core_pkg.sv
// core_pkg: shared size encodings and FSM state type for the memory-stage L1D interface.
package core_pkg;
   localparam logic [1:0] MEM_SZ_B   = 2'b00;
   localparam logic [1:0] MEM_SZ_H   = 2'b01;
   localparam logic [1:0] MEM_SZ_W   = 2'b10;
   localparam logic [1:0] MEM_SZ_ILL = 2'b11;
   typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;
endpackage

// File: rtl/core_mem_align.sv
// core_mem_align: byte-lane logic; request side uses the live op, response side the registered op.
module core_mem_align
   import core_pkg::*;
(
   input  logic [1:0]  req_size,
   input  logic [1:0]  req_ofs,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  rsp_size,
   input  logic [1:0]  rsp_ofs,
   input  logic [31:0] rsp_rdata,
   output logic        aligned,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_al
);
   logic [31:0] sh;
   always_comb begin
      aligned   = (req_size == MEM_SZ_B) | ((req_size == MEM_SZ_H) & ~req_ofs[0]) |
                  ((req_size == MEM_SZ_W) & (req_ofs == 2'b00));
      be        = (req_size == MEM_SZ_B) ? 4'b0001 << req_ofs :
                  (req_size == MEM_SZ_H) ? 4'b0011 << req_ofs : 4'b1111;
      wdata_rep = (req_size == MEM_SZ_B) ? {4{req_wdata[7:0]}} :
                  (req_size == MEM_SZ_H) ? {2{req_wdata[15:0]}} : req_wdata;
      sh        = rsp_rdata >> {rsp_ofs, 3'b000};
      rdata_al  = (rsp_size == MEM_SZ_B) ? {24'h0, sh[7:0]} :
                  (rsp_size == MEM_SZ_H) ? {16'h0, sh[15:0]} : sh;
   end
endmodule

// File: rtl/core_mem_s.sv
// core_mem_s: memory-stage FSM issuing single L1D requests; define CORE_MEM_TIMEOUT_EN
// to abandon a request that sees no ack within 2^TMO_W-1 cycles.
module core_mem_s
   import core_pkg::*;
#(
   parameter int TMO_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_in,
   input  logic        mem_we_in,
   input  logic [1:0]  mem_size_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] mem_wdata_in,
   input  logic        mem_kill_in,
   output logic        l1d_req_out,
   output logic        l1d_we_out,
   output logic [31:0] l1d_addr_out,
   output logic [3:0]  l1d_be_out,
   output logic [31:0] l1d_wdata_out,
   input  logic        l1d_ack_in,
   input  logic [31:0] l1d_rdata_in,
   output logic [31:0] mem_data_out,
   output logic        mem_ack_out,
   output logic        mem_stall_out,
   output logic        mem_misalign_out,
   output logic        mem_err_out
);
   mem_state_t  state;
   logic        aligned, accept, drop, tmo;
   logic [1:0]  size_q, ofs_q;
   logic [3:0]  be;
   logic [31:0] wrep, rdal;

   core_mem_align u_align (
      .req_size (mem_size_in),
      .req_ofs  (mem_addr_in[1:0]),
      .req_wdata(mem_wdata_in),
      .rsp_size (size_q),
      .rsp_ofs  (ofs_q),
      .rsp_rdata(l1d_rdata_in),
      .aligned  (aligned),
      .be       (be),
      .wdata_rep(wrep),
      .rdata_al (rdal)
   );

   assign accept        = (state == IDLE) & mem_valid_in & ~mem_kill_in & aligned;
   assign mem_stall_out = accept | (state == REQ);

`ifdef CORE_MEM_TIMEOUT_EN
   logic [TMO_W-1:0] cnt;
   assign tmo = &cnt[TMO_W-1:1] & ~cnt[0];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt         <= '0;
         mem_err_out <= 1'b0;
      end else begin
         cnt         <= (state == REQ) ? cnt + 1'b1 : '0;
         mem_err_out <= (state == REQ) & ~l1d_ack_in & tmo;
      end
`else
   // TMO_W only sizes the timeout counter, so without it no timeout can fire
   assign tmo         = TMO_W < 1;
   assign mem_err_out = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state            <= IDLE;
         l1d_req_out      <= 1'b0;
         l1d_we_out       <= 1'b0;
         l1d_addr_out     <= '0;
         l1d_be_out       <= '0;
         l1d_wdata_out    <= '0;
         mem_data_out     <= '0;
         mem_ack_out      <= 1'b0;
         mem_misalign_out <= 1'b0;
         drop             <= 1'b0;
         size_q           <= '0;
         ofs_q            <= '0;
      end else begin
         mem_misalign_out <= (state == IDLE) & mem_valid_in & ~mem_kill_in & ~aligned;
         mem_ack_out      <= 1'b0;
         if (state == IDLE) begin
            if (accept) begin
               state         <= REQ;
               l1d_req_out   <= 1'b1;
               l1d_we_out    <= mem_we_in;
               l1d_addr_out  <= {mem_addr_in[31:2], 2'b00};
               l1d_be_out    <= be;
               l1d_wdata_out <= wrep;
               size_q        <= mem_size_in;
               ofs_q         <= mem_addr_in[1:0];
               drop          <= 1'b0;
            end
         end else if (state == REQ) begin
            if (mem_kill_in) drop <= 1'b1;
            if (l1d_ack_in) begin
               state       <= RESP;
               l1d_req_out <= 1'b0;
               // a kill landing with the ack still counts as a flush
               if (~(drop | mem_kill_in)) begin
                  mem_ack_out  <= 1'b1;
                  mem_data_out <= l1d_we_out ? 32'h0 : rdal;
               end
            end else if (tmo) begin
               state       <= IDLE;
               l1d_req_out <= 1'b0;
            end
         end else begin
            state <= IDLE;
         end
      end
endmodule
